// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues credit-limited requests to an in-order imem,
// buffers responses in a small FIFO and drives the registered IF/ID pc/instr/valid.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        if_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] kill_cnt_q, kill_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_if_q, pc_if_d;
  logic [31:0]   instr_if_q, instr_if_d;
  logic          if_valid_q, if_valid_d;

  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic redirect;
  logic credit_ok;
  logic accept;
  logic push;
  logic advance;
  logic pop;

  // A redirect only counts when decode is not stalled; it also suppresses issue.
  assign redirect  = branch_taken && !stall;
  assign credit_ok = (32'(outstanding_q) + 32'(count_q)) < FIFO_DEPTH;
  assign imem_req  = rst && !redirect && (outstanding_q < OW'(MAX_OUT)) && credit_ok;
  assign accept    = imem_req && imem_ready;
  assign push      = imem_rvalid && !redirect && (kill_cnt_q == '0);
  assign advance   = !stall && !redirect;
  assign pop       = advance && (count_q != '0);

  assign imem_addr = fetch_pc_q;
  assign pc_if     = pc_if_q;
  assign instr_if  = instr_if_q;
  assign if_valid  = if_valid_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(imem_rvalid);
    kill_cnt_d    = kill_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    pc_if_d       = pc_if_q;
    instr_if_d    = instr_if_q;
    if_valid_d    = if_valid_q;

    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;

    if (imem_rvalid && (kill_cnt_q != '0)) kill_cnt_d = kill_cnt_q - OW'(1);

    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      pc_if_d    = fifo_pc_q[rd_ptr_q];
      instr_if_d = fifo_instr_q[rd_ptr_q];
      if_valid_d = 1'b1;
    end else if (advance) begin
      instr_if_d = NOP;
      if_valid_d = 1'b0;
    end

    // Every request still in flight belongs to the old path, including one answered now.
    if (redirect) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      resp_pc_d  = {branch_target[31:2], 2'b00};
      kill_cnt_d = outstanding_q - OW'(imem_rvalid);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      instr_if_d = NOP;
      if_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pc_if_q       <= RESET_PC;
      instr_if_q    <= NOP;
      if_valid_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_if_q       <= pc_if_d;
      instr_if_q    <= instr_if_d;
      if_valid_q    <= if_valid_d;
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: randomized in-order memory with variable latency,
// a queue-based reference model of the fetch stream, and directed literal checks.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_if(pc_if), .instr_if(instr_if), .if_valid(if_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Control values applied to the DUT on the next negedge.
  logic        c_rst, c_stall, c_br, c_ready;
  logic [31:0] c_tgt;

  // Memory environment: in-order queue of accepted requests with due edge numbers.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    ecnt    = 0;
  int    lat_min = 1;
  int    lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference model: requests in flight (with a killed mark), buffered words, IF/ID view.
  typedef struct { logic [31:0] addr; bit killed; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fent_t;
  infl_t       m_infl[$];
  fent_t       m_fifo[$];
  logic [31:0] m_fetch, m_pc, m_instr;
  logic        m_valid;
  bit          model_init = 0;

  function automatic bit model_req();
    if (!c_rst) return 0;
    if (c_br && !c_stall) return 0;
    return (m_infl.size() < MAX_OUT) && ((m_infl.size() + m_fifo.size()) < FIFO_DEPTH);
  endfunction

  task automatic compare_all();
    bit er;
    er = model_req();
    check("imem_req", 32'(imem_req), 32'(er));
    if (er) check("imem_addr", imem_addr, m_fetch);
    if (model_init) begin
      check("pc_if", pc_if, m_pc);
      check("instr_if", instr_if, m_instr);
      check("if_valid", 32'(if_valid), 32'(m_valid));
    end
  endtask

  task automatic update_model();
    bit    req;
    bit    redirect;
    infl_t e;
    fent_t f;
    ecnt++;
    if (!c_rst) begin
      mem_q.delete();
      m_infl.delete();
      m_fifo.delete();
      m_fetch    = RESET_PC;
      m_pc       = RESET_PC;
      m_instr    = NOP;
      m_valid    = 1'b0;
      model_init = 1;
      return;
    end
    // Environment side: the memory follows what the DUT actually does.
    if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (imem_req && imem_ready) begin
      mreq_t r;
      r.addr = imem_addr;
      r.due  = ecnt + $urandom_range(lat_max, lat_min);
      mem_q.push_back(r);
    end
    // Model side.
    req      = model_req();
    redirect = c_br && !c_stall;
    if (redirect) begin
      if (imem_rvalid && m_infl.size() > 0) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].killed = 1;
      m_fifo.delete();
      m_fetch = {c_tgt[31:2], 2'b00};
      m_instr = NOP;
      m_valid = 1'b0;
    end else begin
      if (!c_stall) begin
        if (m_fifo.size() > 0) begin
          f       = m_fifo.pop_front();
          m_pc    = f.pc;
          m_instr = f.instr;
          m_valid = 1'b1;
        end else begin
          m_instr = NOP;
          m_valid = 1'b0;
        end
      end
      if (imem_rvalid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.killed) begin
          f.pc    = e.addr;
          f.instr = imem_rdata;
          m_fifo.push_back(f);
        end
      end
      if (req && c_ready) begin
        e.addr   = m_fetch;
        e.killed = 0;
        m_infl.push_back(e);
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rst           = c_rst;
    stall         = c_stall;
    branch_taken  = c_br;
    branch_target = c_tgt;
    imem_ready    = c_ready;
    if (c_rst && mem_q.size() > 0 && mem_q[0].due <= ecnt + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    compare_all();
    @(posedge clk);
    update_model();
  endtask

  // Runs until the DUT shows a valid instruction, bounded; returns 1 if one appeared.
  task automatic wait_valid(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      #2;
      found = (if_valid === 1'b1);
    end
  endtask

  initial begin
    bit          found;
    logic [31:0] held_addr;

    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    c_rst = 1'b0; c_stall = 1'b0; c_br = 1'b0; c_tgt = '0; c_ready = 1'b1;

    // Reset for two cycles.
    tick(); tick();
    #2;
    check("reset_pc_if", pc_if, RESET_PC);
    check("reset_instr_if", instr_if, NOP);
    check("reset_if_valid", 32'(if_valid), 32'd0);

    // Streaming with latency 1.
    c_rst = 1'b1;
    tick(); #2;
    check("stream_addr1", imem_addr, 32'h4);
    check("stream_valid1", 32'(if_valid), 32'd0);
    tick(); #2;
    check("stream_addr2", imem_addr, 32'h8);
    check("stream_valid2", 32'(if_valid), 32'd0);
    tick(); #2;
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_pc", pc_if, 32'h0);
    check("first_instr", instr_if, mem_word(32'h0));
    tick(); #2;
    check("second_pc", pc_if, 32'h4);
    tick(); #2;
    check("third_pc", pc_if, 32'h8);

    // Stall holds the IF/ID register at pc 8.
    c_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      check("stall_hold_pc", pc_if, 32'h8);
      check("stall_hold_instr", instr_if, mem_word(32'h8));
    end
    c_stall = 1'b0;
    tick(); #2;
    check("after_stall_pc12", pc_if, 32'hC);
    tick(); #2;
    check("after_stall_pc16", pc_if, 32'h10);

    // Redirect with two requests in flight at latency 4.
    lat_min = 4; lat_max = 4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = (m_infl.size() == 2);
    end
    check("redirect_setup", 32'(found), 32'd1);
    c_br = 1'b1; c_tgt = 32'h0000_0100;
    tick(); #2;
    c_br = 1'b0;
    check("redirect_bubble_valid", 32'(if_valid), 32'd0);
    check("redirect_bubble_instr", instr_if, NOP);
    wait_valid(found);
    check("redirect_found1", 32'(found), 32'd1);
    check("redirect_pc100", pc_if, 32'h100);
    wait_valid(found);
    check("redirect_found2", 32'(found), 32'd1);
    check("redirect_pc104", pc_if, 32'h104);

    // A branch under stall is ignored; the same branch unstalled redirects.
    c_stall = 1'b1; c_br = 1'b1; c_tgt = 32'h0000_0202;
    tick(); #2;
    check("stalled_branch_pc", pc_if, 32'h104);
    check("stalled_branch_valid", 32'(if_valid), 32'd1);
    c_stall = 1'b0;
    tick(); #2;
    c_br = 1'b0;
    check("late_branch_valid", 32'(if_valid), 32'd0);
    check("late_branch_pc", pc_if, 32'h104);
    wait_valid(found);
    check("late_branch_found", 32'(found), 32'd1);
    check("late_branch_target", pc_if, 32'h200);

    // Memory not ready for 5 cycles: the request address must stay put.
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 6; i++) tick();
    c_ready = 1'b0;
    held_addr = m_fetch;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      check("ready_low_addr_hold", imem_addr, held_addr);
    end
    c_ready = 1'b1;

    // Randomized traffic with occasional mid-stream reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      c_rst   = ($urandom_range(199) != 0);
      c_stall = ($urandom_range(3) == 0);
      c_br    = ($urandom_range(19) == 0);
      c_tgt   = $urandom;
      c_ready = ($urandom_range(3) != 0);
      tick();
      if (!c_rst) begin
        #2;
        check("mid_reset_pc_if", pc_if, RESET_PC);
        check("mid_reset_valid", 32'(if_valid), 32'd0);
        check("mid_reset_addr", imem_addr, RESET_PC);
      end
    end
    c_rst = 1'b1; c_stall = 1'b0; c_br = 1'b0; c_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Produces the pc_if / instr_if stream that the decode stage consumes.
- Honours the decode-stage stall and branch redirect (branch_taken / branch_target).
- Talks to a variable-latency, in-order instruction memory through a request/response handshake.
- Buffers responses in a small fetch FIFO. Inserts NOP bubbles (0x00000013) when no instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 4, fetch buffer entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding imem requests (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
imem_req  out  1  request valid
imem_addr  out  32  request word address, bits[1:0] always 0
imem_ready  in  1  memory accepts request this cycle when imem_req && imem_ready
imem_rvalid  in  1  response valid, in order, latency >=1 cycle
imem_rdata  in  32  response instruction word
stall  in  1  decode stall; hold IF/ID outputs
branch_taken  in  1  decode resolved a taken branch
branch_target  in  32  redirect address
pc_if  out  32  IF/ID registered PC
instr_if  out  32  IF/ID registered instruction
if_valid  out  1  instr_if is a real fetched instruction (0 = bubble)

Behaviour:
- Reset (rst=0 at clk edge):
  - fetch_pc = resp_pc = RESET_PC; outstanding = 0; kill_cnt = 0; FIFO empty.
  - pc_if = RESET_PC, instr_if = 0x00000013, if_valid = 0.
  - imem_req is 0 during the reset cycle.
  - Reset mid-operation discards all in-flight responses: responses arriving after reset are not counted or stored. The memory is reset by the same rst.
- redirect = branch_taken && !stall. branch_taken while stall=1 is ignored.
- Request issue:
  - imem_req = !redirect && outstanding < MAX_OUT && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_addr = fetch_pc.
  - On accept (imem_req && imem_ready): fetch_pc += 4, outstanding += 1.
- Response:
  - On imem_rvalid: outstanding -= 1.
  - If kill_cnt > 0: drop the word, kill_cnt -= 1.
  - Otherwise: push {resp_pc, imem_rdata} into the FIFO, then resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. A push to a full FIFO is a design error; flag it with an assertion only.
- IF/ID advance when stall=0 and no redirect:
  - FIFO non-empty: pop head into pc_if / instr_if, if_valid = 1.
  - FIFO empty: instr_if = 0x00000013, if_valid = 0, pc_if unchanged.
  - A push and a pop in the same cycle are both performed. A word pushed this cycle is not poppable until the next cycle (no bypass; fetch-to-ID latency >= 2 cycles).
- stall=1: pc_if, instr_if, if_valid hold. FIFO and requests keep running within credit.
- Redirect cycle:
  - fetch_pc = resp_pc = {branch_target[31:2], 2'b00}.
  - FIFO flushed; no request issued.
  - kill_cnt = outstanding - (imem_rvalid ? 1 : 0). The response arriving this cycle is also dropped.
  - IF/ID loads the bubble: instr_if = 0x00000013, if_valid = 0, pc_if unchanged.
  - Requests resume the next cycle from the target.
- Counters: outstanding and kill_cnt are wide enough for MAX_OUT. fetch_pc and resp_pc wrap modulo 2^32.

Test Plan:
- Reset with rst=0 for 2 cycles, then release, imem_ready=1, latency 1 -> imem_addr 0,4,8,... on consecutive cycles. if_valid first 1 at cycle 3 after release with pc_if=0; pc_if then steps +4 per cycle with the matching instr_if.
- Steady stream, then stall=1 for 3 cycles with pc_if=8 -> pc_if/instr_if hold at 8. Requests stop once outstanding + fifo_count = 4. After release, pc_if=12,16 follow with no gap or duplicate.
- imem latency 3, MAX_OUT=2 -> never more than 2 outstanding. Bubbles (if_valid=0, instr_if=0x00000013) appear whenever the FIFO is empty.
- Redirect with 2 requests in flight (PCs 0x10, 0x14), branch_taken=1, target=0x100, stall=0 -> the next cycle shows a bubble. Both stale responses are dropped; the next valid instruction is pc_if=0x100, then 0x104.
- branch_taken=1 with stall=1 -> no redirect, outputs hold. The same branch with stall=0 next cycle -> redirect occurs. A redirect with imem_rvalid in the same cycle and outstanding=1 -> kill_cnt=0, that response is dropped.
- imem_ready=0 for 5 cycles -> imem_req stays 1 with imem_addr stable, then proceeds. Reset asserted mid-stream -> outputs return to the reset values above and fetch restarts at RESET_PC.
